keccak_squeeze: RTL and testbench
=================================

KECCAK_SQUEEZE -- requirements
Module: keccak_squeeze

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: begin a squeeze; sampled only in IDLE.
REQ-004 SHALL have port mode, input, 1 bit: 0 = SHAKE128 (rate 21 lanes), 1 = SHAKE256 (rate 17 lanes); sampled with start.
REQ-005 SHALL have port out_len, input, 32 bits: number of 64-bit output words requested; sampled with start.
REQ-006 SHALL have port state_in, input, keccak_pkg::k_state: permuted state, indexed [y][x][bit]; captured at start and at perm_done.
REQ-007 SHALL have port perm_start, output, 1 bit: one-cycle request for one Keccak-f[1600] permutation of the state.
REQ-008 SHALL have port perm_done, input, 1 bit: permutation finished; state_in valid this cycle.
REQ-009 SHALL have port dout, output, 64 bits: current output lane; lane bit i on dout[i].
REQ-010 SHALL have port dout_valid, output, 1 bit: dout holds a valid word.
REQ-011 SHALL have port dout_ready, input, 1 bit: consumer accepts the word.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse after the last word is delivered.

Function
REQ-014 SHALL implement FSM states IDLE, OUTPUT, PERM_WAIT and DONE.
REQ-015 In IDLE with start=1: SHALL capture state_in into an internal 1600-bit register, latch the rate from mode, load remaining=out_len, and set lane=0.
REQ-016 From IDLE with start=1: SHALL go to DONE if out_len=0, else to OUTPUT.
REQ-017 Lane index l SHALL map to state element [y=l/5][x=l%5]; dout SHALL equal the captured register's lane at that index.
REQ-018 dout_valid SHALL be 1 only in OUTPUT, so the first word is valid the cycle after start.
REQ-019 A handshake SHALL occur only when dout_valid=1 and dout_ready=1.
REQ-020 Without a handshake: dout and dout_valid SHALL hold, and lane and remaining SHALL be unchanged.
REQ-021 On a handshake with remaining=1: SHALL go to DONE.
REQ-022 On a handshake with remaining>1 and lane=rate-1: SHALL decrement remaining, set lane=0, and go to PERM_WAIT.
REQ-023 On any other handshake: SHALL decrement remaining and increment lane.
REQ-024 perm_start SHALL be registered and high exactly during the first cycle in PERM_WAIT.
REQ-025 In PERM_WAIT: dout_valid SHALL be 0.
REQ-026 In PERM_WAIT: perm_done SHALL be honoured only from the cycle after perm_start.
REQ-027 On an honoured perm_done: SHALL capture state_in and go to OUTPUT, so the next word is valid one cycle after perm_done.
REQ-028 DONE SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-029 start SHALL be ignored outside IDLE.
REQ-030 perm_done SHALL be ignored outside PERM_WAIT.
REQ-031 remaining SHALL be 32-bit unsigned and SHALL never underflow, so out_len up to 2^32-1 is supported.
REQ-032 perm_start SHALL never be issued after the final word; the final squeeze block needs no trailing permutation.

Reset
REQ-033 rst=1 SHALL force IDLE from any state, including mid-OUTPUT and mid-PERM_WAIT, on the next edge.
REQ-034 Reset SHALL clear lane, remaining and the state register to 0.
REQ-035 Reset SHALL drive perm_start, dout_valid, busy and done to 0, and dout to 0 (lane 0 of the cleared register).
REQ-036 A perm_done arriving during or after reset, before a new start, SHALL have no effect.

Verification
REQ-037 mode=0, out_len=3, lane l preloaded with value l, dout_ready=1 -> words 0,1,2 on consecutive cycles starting the cycle after start, done pulse the next cycle, perm_start never asserted.
REQ-038 mode=1, out_len=18 -> 17 words (lanes 0..16); single perm_start pulse after word 17; dout_valid low until perm_done; perm_done with lane0=0xDEADBEEF00000001 -> word 18 = 0xDEADBEEF00000001; then done.
REQ-039 out_len=0 -> done high the cycle after start, dout_valid never high, perm_start never high.
REQ-040 dout_ready held low 5 cycles during word 2 -> dout and dout_valid stable for all 5 cycles, no word skipped or duplicated after release.
REQ-041 rst asserted in PERM_WAIT, then perm_done pulsed -> module stays IDLE with all outputs 0; a new start with out_len=1 then delivers lane 0 normally.
REQ-042 start pulsed during OUTPUT with a different out_len -> ignored; the original word count completes unchanged.

Source files
------------

// File: rtl/keccak_squeeze.sv
// Keccak squeeze stage: streams rate lanes of the permuted state as 64-bit words
// and requests another permutation each time a rate block is used up.
package keccak_pkg;
  typedef logic [4:0][4:0][63:0] k_state;
endpackage

module keccak_squeeze (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic [31:0]        out_len,
  input  keccak_pkg::k_state state_in,
  output logic               perm_start,
  input  logic               perm_done,
  output logic [63:0]        dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, OUTPUT, PERM_WAIT, DONE} fsm_e;

  fsm_e               fsm_q, fsm_d;
  keccak_pkg::k_state st_q, st_d;
  logic [4:0]         last_lane_q, last_lane_d;
  logic [4:0]         lane_q, lane_d;
  logic [31:0]        remaining_q, remaining_d;
  logic               perm_start_q, perm_start_d;
  logic [63:0]        lanes [0:24];

  // Linear lane l lives at [y = l/5][x = l%5].
  for (genvar gi = 0; gi < 25; gi++) begin : g_lane
    assign lanes[gi] = st_q[gi / 5][gi % 5];
  end

  always_comb begin
    fsm_d        = fsm_q;
    st_d         = st_q;
    last_lane_d  = last_lane_q;
    lane_d       = lane_q;
    remaining_d  = remaining_q;
    perm_start_d = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start) begin
          st_d        = state_in;
          last_lane_d = mode ? 5'd16 : 5'd20;
          remaining_d = out_len;
          lane_d      = 5'd0;
          fsm_d       = (out_len == 32'd0) ? DONE : OUTPUT;
        end
      end
      OUTPUT: begin
        if (dout_ready) begin
          if (remaining_q <= 32'd1) begin
            // Final word: no trailing permutation, and remaining never wraps.
            remaining_d = 32'd0;
            fsm_d       = DONE;
          end else begin
            remaining_d = remaining_q - 32'd1;
            if (lane_q == last_lane_q) begin
              lane_d       = 5'd0;
              perm_start_d = 1'b1;
              fsm_d        = PERM_WAIT;
            end else begin
              lane_d = lane_q + 5'd1;
            end
          end
        end
      end
      PERM_WAIT: begin
        // A done coincident with our own request belongs to an older permutation.
        if (perm_done && !perm_start_q) begin
          st_d  = state_in;
          fsm_d = OUTPUT;
        end
      end
      DONE:    fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q        <= IDLE;
      st_q         <= '0;
      last_lane_q  <= 5'd0;
      lane_q       <= 5'd0;
      remaining_q  <= 32'd0;
      perm_start_q <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      st_q         <= st_d;
      last_lane_q  <= last_lane_d;
      lane_q       <= lane_d;
      remaining_q  <= remaining_d;
      perm_start_q <= perm_start_d;
    end
  end

  assign dout       = lanes[lane_q];
  assign dout_valid = (fsm_q == OUTPUT);
  assign busy       = (fsm_q != IDLE);
  assign done       = (fsm_q == DONE);
  assign perm_start = perm_start_q;

endmodule

// File: tb/tb_keccak_squeeze.sv
// Directed bench for keccak_squeeze: expected words are queued as stimulus is
// driven and popped on every observed handshake.
module tb_keccak_squeeze;

  logic               clk = 1'b0;
  logic               rst, start, mode, perm_done, dout_ready;
  logic [31:0]        out_len;
  keccak_pkg::k_state state_in;
  logic               perm_start, dout_valid, busy, done;
  logic [63:0]        dout;

  keccak_squeeze dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .out_len(out_len),
    .state_in(state_in), .perm_start(perm_start), .perm_done(perm_done),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          perm_cnt = 0;
  logic [63:0] sb [$];
  logic        s_valid, s_done, s_perm, s_busy;
  logic [63:0] s_dout;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_dout = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_state(input logic [63:0] base);
    for (int l = 0; l < 25; l++) state_in[l / 5][l % 5] = base + 64'(l);
  endtask

  // One clock: sample and score outputs on the falling edge, then step past the rising edge.
  task automatic tick();
    logic [63:0] exp;
    @(negedge clk);
    s_valid = dout_valid; s_done = done; s_perm = perm_start;
    s_busy = busy; s_dout = dout;
    if (prev_stall) begin
      check("stall_valid", dout_valid, 1'b1);
      check("stall_dout", dout, prev_dout);
    end
    prev_stall = dout_valid && !dout_ready;
    prev_dout  = dout;
    if (perm_start) begin
      perm_cnt++;
      check("perm_valid_low", dout_valid, 1'b0);
    end
    if (dout_valid && dout_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL extra_word observed=%h expected=none", dout);
      end
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        check("word", dout, exp);
        $display("word %h expected %h", dout, exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic m, input logic [31:0] len);
    mode = m; out_len = len; start = 1'b1; perm_cnt = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int n = 0;
    do begin tick(); n++; end while (!s_done && n < budget);
    check(tag, s_done, 1'b1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; perm_done = 1'b0; dout_ready = 1'b1;
    out_len = '0; load_state(64'd0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_valid", s_valid, 1'b0);
    check("rst_busy", s_busy, 1'b0);
    check("rst_done", s_done, 1'b0);
    check("rst_perm", s_perm, 1'b0);
    check("rst_dout", s_dout, 64'd0);

    // SHAKE128, three words back to back, no permutation
    load_state(64'd0);
    for (int l = 0; l < 3; l++) sb.push_back(64'(l));
    do_start(1'b0, 32'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_valid", s_valid, 1'b1);
    end
    tick();
    check("t1_done", s_done, 1'b1);
    check("t1_valid_off", s_valid, 1'b0);
    tick();
    check("t1_done_once", s_done, 1'b0);
    check("t1_idle", s_busy, 1'b0);
    check("t1_perm_cnt", 64'(perm_cnt), 64'd0);
    check("t1_sb_empty", 64'(sb.size()), 64'd0);

    // SHAKE256, 18 words across one permutation
    load_state(64'h100);
    for (int l = 0; l < 17; l++) sb.push_back(64'h100 + 64'(l));
    sb.push_back(64'hDEADBEEF00000001);
    do_start(1'b1, 32'd18);
    for (int n = 0; n < 60 && sb.size() > 1; n++) tick();
    check("t2_17_words", 64'(sb.size()), 64'd1);
    state_in[0][0] = 64'hBAD0BAD0BAD0BAD0;
    perm_done = 1'b1;  // coincides with perm_start: must be ignored
    tick();
    check("t2_perm_pulse", s_perm, 1'b1);
    perm_done = 1'b0;
    state_in[0][0] = 64'hDEADBEEF00000001;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_wait_valid", s_valid, 1'b0);
      check("t2_wait_perm", s_perm, 1'b0);
    end
    perm_done = 1'b1;
    tick();
    check("t2_pd_valid", s_valid, 1'b0);
    perm_done = 1'b0;
    tick();
    check("t2_word18_valid", s_valid, 1'b1);
    tick();
    check("t2_done", s_done, 1'b1);
    check("t2_perm_cnt", 64'(perm_cnt), 64'd1);
    check("t2_sb_empty", 64'(sb.size()), 64'd0);
    tick();

    // Zero-length request
    do_start(1'b0, 32'd0);
    tick();
    check("t3_done", s_done, 1'b1);
    check("t3_valid", s_valid, 1'b0);
    tick();
    check("t3_idle", s_busy, 1'b0);
    check("t3_perm_cnt", 64'(perm_cnt), 64'd0);

    // Back-pressure on word 2, plus a stray perm_done that must not reload
    load_state(64'h5500);
    for (int l = 0; l < 5; l++) sb.push_back(64'h5500 + 64'(l));
    do_start(1'b0, 32'd5);
    tick(); tick();
    dout_ready = 1'b0;
    load_state(64'h7700);
    perm_done = 1'b1;
    tick();
    perm_done = 1'b0;
    check("t4_stall_dout", s_dout, 64'h5502);
    repeat (4) tick();
    dout_ready = 1'b1;
    run_until_done("t4_done", 20);
    check("t4_sb_empty", 64'(sb.size()), 64'd0);
    tick();

    // Reset while waiting on a permutation
    load_state(64'h9000);
    for (int l = 0; l < 21; l++) sb.push_back(64'h9000 + 64'(l));
    do_start(1'b0, 32'd22);
    for (int n = 0; n < 40 && !s_perm; n++) tick();
    check("t5_perm_seen", s_perm, 1'b1);
    check("t5_sb_empty", 64'(sb.size()), 64'd0);
    rst = 1'b1; perm_done = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    perm_done = 1'b0;
    tick();
    check("t5_busy", s_busy, 1'b0);
    check("t5_valid", s_valid, 1'b0);
    check("t5_done", s_done, 1'b0);
    check("t5_perm", s_perm, 1'b0);
    check("t5_dout", s_dout, 64'd0);
    load_state(64'hA000);
    sb.push_back(64'hA000);
    do_start(1'b0, 32'd1);
    run_until_done("t5_restart_done", 10);
    check("t5_restart_sb", 64'(sb.size()), 64'd0);
    tick();

    // start during OUTPUT must not change the word count
    load_state(64'hC000);
    for (int l = 0; l < 4; l++) sb.push_back(64'hC000 + 64'(l));
    do_start(1'b0, 32'd4);
    tick();
    start = 1'b1; out_len = 32'd10;
    tick();
    start = 1'b0;
    run_until_done("t6_done", 20);
    check("t6_sb_empty", 64'(sb.size()), 64'd0);
    repeat (3) tick();
    check("t6_idle", s_busy, 1'b0);
    check("t6_no_extra", s_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
